// File: rtl/argmax_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : argmax_seq_ctrl_if
// Description : Bundles the control, score-stream and result-stream signals
//               of the argmax sequencing stage.
//               master : top-level sequencer / final layer / result consumer
//               slave  : argmax_seq_ctrl
//   start, abort               sequencer -> block
//   score_valid, score_data    final layer -> block
//   score_ready                block -> final layer
//   result_valid, result_index, result_max   block -> result logic
//   result_ready               result logic -> block
//   busy                       block -> sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface argmax_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) ();
  logic                  start;
  logic                  abort;
  logic                  score_valid;
  logic                  score_ready;
  logic [DATA_WIDTH-1:0] score_data;
  logic                  result_valid;
  logic                  result_ready;
  logic [IDX_WIDTH-1:0]  result_index;
  logic [DATA_WIDTH-1:0] result_max;
  logic                  busy;

  modport master (
    output start, abort, score_valid, score_data, result_ready,
    input  score_ready, result_valid, result_index, result_max, busy
  );

  modport slave (
    input  start, abort, score_valid, score_data, result_ready,
    output score_ready, result_valid, result_index, result_max, busy
  );
endinterface
`default_nettype wire

// File: rtl/argmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : argmax_seq_ctrl
// Description : Collects NUM_CLASSES class scores serially, tracks the running
//               unsigned maximum (ties keep the lowest index) and presents the
//               winning index/score over a valid/ready handshake.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - argmax_seq_ctrl_if.slave (control, score stream,
//                       result stream, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  wire              clk,
  input  wire              rst_n,
  argmax_seq_ctrl_if.slave bus
);

  generate
    if ((NUM_CLASSES < 2) || (NUM_CLASSES > 16) ||
        ((1 << IDX_WIDTH) < NUM_CLASSES)) begin : g_param_check
      $error("argmax_seq_ctrl: invalid NUM_CLASSES / IDX_WIDTH combination");
    end
  endgenerate

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] run_max;
  logic [IDX_WIDTH-1:0]  run_idx;
  logic                  result_valid_reg;
  logic [IDX_WIDTH-1:0]  result_index_reg;
  logic [DATA_WIDTH-1:0] result_max_reg;

  logic                  score_ready_int;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] next_max;
  logic [IDX_WIDTH-1:0]  next_idx;

  // Abort masks ready so a score offered in the abort cycle is never taken.
  assign score_ready_int = (state == COLLECT) && !bus.abort;
  assign transfer        = bus.score_valid && score_ready_int;

  // Running max including the score currently on the bus. The first score of
  // a frame is taken unconditionally (count == 0 also yields index 0), so no
  // stale maximum from an earlier or aborted frame can leak through.
  always_comb begin
    next_max = run_max;
    next_idx = run_idx;
    if ((count == '0) || (bus.score_data > run_max)) begin
      next_max = bus.score_data;
      next_idx = count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      run_max          <= '0;
      run_idx          <= '0;
      result_valid_reg <= 1'b0;
      result_index_reg <= '0;
      result_max_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state <= COLLECT;
            count <= '0;
          end
        end

        COLLECT: begin
          if (bus.abort) begin
            state <= IDLE;
            count <= '0;
          end else if (transfer) begin
            run_max <= next_max;
            run_idx <= next_idx;
            if (count == LAST_IDX) begin
              // Final score: publish the result including this score.
              state            <= DONE;
              count            <= '0;
              result_valid_reg <= 1'b1;
              result_index_reg <= next_idx;
              result_max_reg   <= next_max;
            end else begin
              count <= count + IDX_WIDTH'(1);
            end
          end
        end

        DONE: begin
          // Result registers are left untouched on exit so downstream logic
          // can keep displaying the last winner.
          if (bus.abort || bus.result_ready) begin
            state            <= IDLE;
            count            <= '0;
            result_valid_reg <= 1'b0;
          end
        end

        default: begin
          state            <= IDLE;
          count            <= '0;
          result_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score_ready  = score_ready_int;
  assign bus.result_valid = result_valid_reg;
  assign bus.result_index = result_index_reg;
  assign bus.result_max   = result_max_reg;
  assign bus.busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_argmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_seq_ctrl
// Description : Scoreboard bench for argmax_seq_ctrl. The driver pushes the
//               hand-computed winner of each frame into a queue; a monitor
//               pops and compares on every result handshake. Control-path
//               behaviour (latency, backpressure, abort, reset) is checked
//               inline by the driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_seq_ctrl;

  localparam int DW = 16;
  localparam int NC = 10;
  localparam int IW = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] mx;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   total_checks;
  int   pass_checks;

  argmax_seq_ctrl_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  argmax_seq_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_CLASSES(NC),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_checks++;
    if (act === req) pass_checks++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid && bus.result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_index", 32'(bus.result_index), 32'(e.idx));
        check("result_max", 32'(bus.result_max), 32'(e.mx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Offer one score and return one time unit after the edge that takes it.
  task automatic push_score(input logic [DW-1:0] d, output logic rv_before);
    int guard;
    guard = 0;
    bus.score_valid = 1'b1;
    bus.score_data  = d;
    @(negedge clk);
    while (!bus.score_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("score_ready_timeout", 32'd0, 32'd1);
    rv_before = bus.result_valid;
    @(posedge clk);
    #1;
    bus.score_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] s[NC], input int max_gap,
                           input bit start_mid, input exp_t e);
    logic rv;
    exp_q.push_back(e);
    pulse_start();
    check("busy_after_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < NC; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int k = 0; k < g; k++) tick();
      end
      if (start_mid && i == 3) pulse_start();
      push_score(s[i], rv);
      if (i == NC - 1) begin
        check("result_valid_low_during_last", 32'(rv), 32'd0);
        check("result_valid_latency", 32'(bus.result_valid), 32'd1);
        check("score_ready_in_done", 32'(bus.score_ready), 32'd0);
      end
    end
  endtask

  logic [DW-1:0] fa[NC] = '{16'd3, 16'd9, 16'd1, 16'd7, 16'd9, 16'd2, 16'd0, 16'd4, 16'd8, 16'd5};
  logic [DW-1:0] fb[NC] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  logic [DW-1:0] fc[NC] = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [DW-1:0] fd[NC] = '{16'd10, 16'd20, 16'd5, 16'd20, 16'd30, 16'd1, 16'd30, 16'd2, 16'd29, 16'd3};
  logic [DW-1:0] fe[NC] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
  logic [DW-1:0] ff[NC] = '{16'd7, 16'd3, 16'd7, 16'd8, 16'd1, 16'd8, 16'd2, 16'd0, 16'd6, 16'd8};

  initial begin
    logic rv;
    total_checks     = 0;
    pass_checks      = 0;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.score_valid  = 1'b0;
    bus.score_data   = '0;
    bus.result_ready = 1'b1;

    #3;
    check("rst_score_ready", 32'(bus.score_ready), 32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result_index", 32'(bus.result_index), 32'd0);
    check("rst_result_max", 32'(bus.result_max), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // Ties keep the first occurrence.
    run_frame(fa, 0, 1'b0, '{idx: 4'd1, mx: 16'd9});
    tick();
    check("idle_after_handshake_busy", 32'(bus.busy), 32'd0);
    check("idle_after_handshake_valid", 32'(bus.result_valid), 32'd0);
    check("result_kept_after_handshake", 32'(bus.result_max), 32'd9);

    // score_valid in IDLE must not be accepted.
    bus.score_valid = 1'b1;
    bus.score_data  = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      check("idle_score_ready", 32'(bus.score_ready), 32'd0);
      tick();
    end
    bus.score_valid = 1'b0;
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Max in last position, plus an ignored start pulse mid-collect.
    run_frame(fb, 0, 1'b1, '{idx: 4'd9, mx: 16'd9});
    tick();
    // Max in first position.
    run_frame(fc, 0, 1'b0, '{idx: 4'd0, mx: 16'hFFFF});
    tick();

    // Backpressure: valid gaps, then result held for 5 cycles.
    bus.result_ready = 1'b0;
    run_frame(fd, 2, 1'b0, '{idx: 4'd4, mx: 16'd30});
    for (int i = 0; i < 5; i++) begin
      check("bp_result_valid", 32'(bus.result_valid), 32'd1);
      check("bp_score_ready", 32'(bus.score_ready), 32'd0);
      check("bp_result_index", 32'(bus.result_index), 32'd4);
      check("bp_result_max", 32'(bus.result_max), 32'd30);
      bus.start       = (i == 2);
      bus.score_valid = (i == 3);
      tick();
    end
    bus.start       = 1'b0;
    bus.score_valid = 1'b0;
    // Handshake together with a start that must be ignored.
    bus.result_ready = 1'b1;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check("bp_idle_busy", 32'(bus.busy), 32'd0);
    check("bp_idle_valid", 32'(bus.result_valid), 32'd0);
    tick();
    check("start_at_handshake_ignored", 32'(bus.busy), 32'd0);

    // Abort after 4 transfers.
    pulse_start();
    for (int i = 0; i < 4; i++) push_score(16'(100 * (i + 1)), rv);
    bus.abort       = 1'b1;
    bus.score_valid = 1'b1;
    bus.score_data  = 16'd999;
    #1;
    check("abort_masks_ready", 32'(bus.score_ready), 32'd0);
    tick();
    bus.abort       = 1'b0;
    bus.score_valid = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_no_valid", 32'(bus.result_valid), 32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_idle_noop", 32'(bus.busy), 32'd0);
    run_frame(fe, 0, 1'b0, '{idx: 4'd0, mx: 16'd5});
    tick();

    // Asynchronous reset between edges mid-collect.
    pulse_start();
    for (int i = 0; i < 3; i++) push_score(16'd50, rv);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_score_ready", 32'(bus.score_ready), 32'd0);
    check("async_rst_result_max", 32'(bus.result_max), 32'd0);
    check("async_rst_result_index", 32'(bus.result_index), 32'd0);
    check("async_rst_result_valid", 32'(bus.result_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    run_frame(ff, 1, 1'b0, '{idx: 4'd3, mx: 16'd8});
    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
